// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) xtime, FSM encoding and
// FIPS-197 byte/column slicing of a 128-bit state.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] get_col(
    input logic [127:0] s,
    input logic [1:0]   c
  );
    return s[127-32*int'(c) -: 32];
  endfunction

  function automatic logic [127:0] put_col(
    input logic [127:0] s,
    input logic [1:0]   c,
    input logic [31:0]  v
  );
    logic [127:0] r;
    r = s;
    r[127-32*int'(c) -: 32] = v;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(
    input logic [31:0] w,
    input logic [1:0]  r
  );
    return w[31-8*int'(r) -: 8];
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// One-column (Inv)MixColumns multiply, purely combinational.
// GF products come from xtime chains rather than tables.
module mix_single_column
  import aes_pkg::*;
#(
  parameter int INVERSE = 0
) (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  function automatic logic [7:0] m9(
    input logic [7:0] x
  );
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mb(
    input logic [7:0] x
  );
    logic [7:0] x2, x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] md(
    input logic [7:0] x
  );
    logic [7:0] x4, x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] me(
    input logic [7:0] x
  );
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] a0, a1, a2, a3;
    assign a0 = get_byte(col_in, 2'(r));
    assign a1 = get_byte(col_in, 2'((r + 1) % 4));
    assign a2 = get_byte(col_in, 2'((r + 2) % 4));
    assign a3 = get_byte(col_in, 2'((r + 3) % 4));

    if (INVERSE != 0) begin : g_inv
      assign col_out[31-8*r -: 8] =
        me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
    end else begin : g_fwd
      assign col_out[31-8*r -: 8] =
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Column-serial MixColumns engine: one 32-bit column per clock,
// done pulse after the fourth column lands in State_Out.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int INVERSE = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         Start,
  input  logic [127:0] State_In,
  output logic         Busy,
  output logic         Done,
  output logic [127:0] State_Out
);

  state_t       state;
  logic [1:0]   col;
  logic [127:0] cap;
  logic [31:0]  col_src;
  logic [31:0]  col_res;

  assign col_src = get_col(cap, col);

  mix_single_column #(
    .INVERSE (INVERSE)
  ) u_col (
    .col_in  (col_src),
    .col_out (col_res)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      col       <= 2'd0;
      cap       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      State_Out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            cap   <= State_In;
            col   <= 2'd0;
            state <= RUN;
            Busy  <= 1'b1;
          end
        end
        RUN: begin
          State_Out <= put_col(State_Out, col, col_res);
          col       <= col + 2'd1;
          if (col == 2'd3) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            Done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
Column-serial AES MixColumns engine: accepts a 128-bit state on a start pulse, transforms one 32-bit column per clock, and returns the full result with a one-cycle done pulse. It is the forward (encryption) counterpart of the decryption-side GF(2^8) constant-multiply tables. A parameter selects the InvMixColumns matrix for decrypt-path reuse. It sits between ShiftRows and AddRoundKey in the round datapath. GF products are computed arithmetically with xtime chains, with no ROM lookups.

Parameters:
INVERSE, 0, 0 = MixColumns matrix {02,03,01,01}; 1 = InvMixColumns matrix {0E,0B,0D,09}, both as circulant rows.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
Start  input  1  request; sampled only when the engine is idle
State_In  input  128  input state, FIPS-197 byte order: column c = bits [127-32c -: 32], row r of that column = bits [127-32c-8r -: 8]
Busy  output  1  high while columns are being processed
Done  output  1  one-cycle pulse; State_Out is valid from this cycle onward
State_Out  output  128  result, same byte order as State_In; held until the next completion overwrites it

Behaviour:
- Reset (asynchronous assert; release is synchronous to CLK):
  - state = IDLE, col counter = 0, captured-state register = 0.
  - Busy = 0, Done = 0, State_Out = 128'h0.
- States: IDLE, RUN.
- IDLE:
  - Start = 1 at edge k: capture State_In, col = 0, go to RUN, Busy <= 1.
  - Start = 0: stay in IDLE.
  - Done <= 0 on every IDLE edge unless the last-column rule below sets it.
- RUN, at edges k+1..k+4:
  - Compute column col from the captured register; write it into the State_Out column slot col; col <= col + 1 (2-bit, wraps to 0).
  - On the col == 3 write: state <= IDLE, Busy <= 0, Done <= 1 for exactly one cycle.
- Timing:
  - Latency: Done is high in the cycle after edge k+4.
  - Start may be high during the Done cycle and is accepted, giving back-to-back throughput of 1 block per 5 cycles.
- Start while Busy is ignored; the captured register is not disturbed.
- Changes to State_In after the capture edge have no effect on the current operation.
- State_Out during RUN: columns update progressively, so partially updated contents are visible. Consumers must use State_Out only at or after Done.
- Reset asserted mid-operation: immediate return to reset values; no Done is issued for the aborted block.
- Column math, for input bytes a0..a3:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - Forward: b_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - Inverse: b_r = E·a_r ^ B·a_(r+1) ^ D·a_(r+2) ^ 9·a_(r+3).
  - 9x = x8 ^ x; Bx = x8 ^ x2 ^ x; Dx = x8 ^ x4 ^ x; Ex = x8 ^ x4 ^ x2, where x2 = xtime(x), x4 = xtime(x2), x8 = xtime(x4).
  - All arithmetic is 8-bit XOR; there are no carries.
- Datapath: exactly one column-multiply instance, muxed by col. There is no combinational path from Start or State_In to any output.

Decomposition:
- Shared package aes_pkg:
  - xtime function.
  - Reduction constant 8'h1B.
  - IDLE/RUN state encoding.
  - Byte/column slice helper functions for the FIPS-197 ordering.
- Sub-module mix_single_column (combinational, 32-bit in and out, INVERSE passed down), instantiated once.

Test Plan:
1. INVERSE=0, column 32'hDB135345 replicated in all four columns, Start pulse -> Done high exactly 5 cycles after the Start edge; State_Out = {4{32'h8E4DA1BC}}; Busy high for 4 cycles.
2. INVERSE=0, State_In = 128'hD4BF5D30_E0B452AE_B84111F1_1E2798E5 (FIPS-197 round 1) -> State_Out = 128'h046681E5_E0CB199A_48F8D37A_2806264C.
3. INVERSE=1, State_In = {4{32'h8E4DA1BC}} -> {4{32'hDB135345}}; also check {4{32'hC6C6C6C6}} -> unchanged, and {4{32'h01010101}} -> unchanged.
4. Start re-pulsed on cycles 2 and 3 of a RUN with a different State_In -> ignored; first result is correct; exactly one Done.
5. Start held high continuously with new data each accept -> a Done every 5 cycles, each result matching its own captured input, no lost or duplicated blocks.
6. RST_N asserted after 2 columns -> Busy, Done and State_Out are 0 immediately; no Done after release; a following Start produces a correct result.
